// File: rtl/bus_region_router.sv
// bus_region_router: single-outstanding region router with one-hot target strobes.
// Define ROUTER_TIMEOUT_EN to add the stalled-target timeout error path.
module bus_region_router #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [15:0]       i_req_addr,
    input  logic              i_req_we,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_tgt_valid,
    output logic [7:0]        o_tgt_sel,
    output logic [11:0]       o_tgt_addr,
    output logic              o_tgt_we,
    output logic [DATA_W-1:0] o_tgt_wdata,
    input  logic              i_tgt_ack,
    input  logic [DATA_W-1:0] i_tgt_rdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [2:0]        o_rsp_region
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [2:0] REG_UNMAPPED = 3'd4;

    state_t              r_state;
    logic                r_req_ready;
    logic [2:0]          r_region;
    logic                r_tgt_valid;
    logic [7:0]          r_tgt_sel;
    logic [11:0]         r_tgt_addr;
    logic                r_tgt_we;
    logic [DATA_W-1:0]   r_tgt_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [2:0]          r_rsp_region;

    logic [2:0]          w_region;
    logic                w_expired;

    always_comb begin
        unique case (i_req_addr[15:12])
            4'h0:    w_region = 3'd0;
            4'h1:    w_region = 3'd1;
            4'h2:    w_region = 3'd2;
            4'h3:    w_region = 3'd3;
            4'hF:    w_region = 3'd7;
            default: w_region = REG_UNMAPPED;
        endcase
    end

`ifdef ROUTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    assign w_expired = (r_cnt == CNT_MAX);

    // Held at zero outside BUS, so every BUS entry starts a fresh count.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != ST_BUS)) begin
            r_cnt <= '0;
        end else if (!i_tgt_ack && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_region     <= '0;
            r_tgt_valid  <= 1'b0;
            r_tgt_sel    <= '0;
            r_tgt_addr   <= '0;
            r_tgt_we     <= 1'b0;
            r_tgt_wdata  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_region <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_region    <= w_region;
                        r_tgt_addr  <= i_req_addr[11:0];
                        r_tgt_we    <= i_req_we;
                        r_tgt_wdata <= i_req_wdata;
                        if (w_region == REG_UNMAPPED) begin
                            r_state      <= ST_RESP;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_err    <= 1'b1;
                            r_rsp_rdata  <= '0;
                            r_rsp_region <= w_region;
                        end else begin
                            r_state     <= ST_BUS;
                            r_tgt_valid <= 1'b1;
                            r_tgt_sel   <= 8'(1) << w_region;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_tgt_ack || w_expired) begin
                        r_state      <= ST_RESP;
                        r_tgt_valid  <= 1'b0;
                        r_tgt_sel    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_region <= r_region;
                        // An ack on the expiry edge still wins.
                        r_rsp_err    <= !i_tgt_ack;
                        if (i_tgt_ack && !r_tgt_we) begin
                            r_rsp_rdata <= i_tgt_rdata;
                        end else begin
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_tgt_valid <= 1'b0;
                    r_tgt_sel   <= '0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_tgt_valid  = r_tgt_valid;
    assign o_tgt_sel    = r_tgt_sel;
    assign o_tgt_addr   = r_tgt_addr;
    assign o_tgt_we     = r_tgt_we;
    assign o_tgt_wdata  = r_tgt_wdata;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_err    = r_rsp_err;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_region = r_rsp_region;

endmodule

// File: tb/tb_bus_region_router.sv
// tb_bus_region_router: randomized scoreboard bench for bus_region_router.
// Target responder and response monitor run as independent processes.
module tb_bus_region_router;

    localparam int DW = 16;
    localparam int TO = 15;

    typedef struct {
        logic [7:0]  sel;
        logic [11:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] rdata;
        bit          stall;
    } plan_t;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic [2:0]  region;
        int          acc_n;
        int          lat;
    } rsp_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [15:0]   i_req_addr;
    logic          i_req_we;
    logic [DW-1:0] i_req_wdata;
    logic          o_tgt_valid;
    logic [7:0]    o_tgt_sel;
    logic [11:0]   o_tgt_addr;
    logic          o_tgt_we;
    logic [DW-1:0] o_tgt_wdata;
    logic          tgt_ack;
    logic [DW-1:0] rdata_r;
    logic          o_rsp_valid;
    logic          o_rsp_err;
    logic [DW-1:0] o_rsp_rdata;
    logic [2:0]    o_rsp_region;

    logic ack_r = 1'b0;
    logic force_ack = 1'b0;
    assign tgt_ack = ack_r | force_ack;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit outstanding = 0;
    plan_t plan_q[$];
    rsp_t  rsp_q[$];

    bus_region_router #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_we     (i_req_we),
        .i_req_wdata  (i_req_wdata),
        .o_tgt_valid  (o_tgt_valid),
        .o_tgt_sel    (o_tgt_sel),
        .o_tgt_addr   (o_tgt_addr),
        .o_tgt_we     (o_tgt_we),
        .o_tgt_wdata  (o_tgt_wdata),
        .i_tgt_ack    (tgt_ack),
        .i_tgt_rdata  (rdata_r),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_region (o_rsp_region)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Region map straight from the address-map table.
    function automatic int model_region(input logic [15:0] a);
        int nib;
        nib = int'(a >> 12);
        if (nib <= 3) return nib;
        if (nib == 15) return 7;
        return 4;
    endfunction

    task automatic do_req(input logic [15:0] a, input logic we,
                          input logic [15:0] wd, input int d,
                          input logic [15:0] rd, input bit stall);
        int n;
        int c0;
        int reg_n;
        plan_t p;
        rsp_t r;
        n = 0;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_we    = we;
        i_req_wdata = wd;
        while (!o_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 200), 32'd1);
        if (n >= 200) begin
            i_req_valid = 1'b0;
            return;
        end
        c0 = cyc;
        @(posedge clk);
        reg_n = model_region(a);
        outstanding = 1;
        if (reg_n == 4) begin
            r = '{1'b1, 16'h0, 3'(reg_n), c0 + 1, 1};
            rsp_q.push_back(r);
        end else begin
            p = '{8'(1 << reg_n), a[11:0], we, wd, d, rd, stall};
            plan_q.push_back(p);
            if (!stall) begin
                r = '{1'b0, we ? 16'h0 : rd, 3'(reg_n), c0 + 1, 2 + d};
                rsp_q.push_back(r);
            end else begin
`ifdef ROUTER_TIMEOUT_EN
                r = '{1'b1, 16'h0, 3'(reg_n), c0 + 1, TO + 2};
                rsp_q.push_back(r);
`endif
            end
        end
        @(negedge clk);
        i_req_valid = 1'b0;
        i_req_addr  = 16'($urandom);
        i_req_we    = 1'($urandom);
        i_req_wdata = 16'($urandom);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge clk);
        chk("rst_tgt_valid", 32'(o_tgt_valid), 32'd0);
        chk("rst_tgt_sel", 32'(o_tgt_sel), 32'd0);
        chk("rst_tgt_addr", 32'(o_tgt_addr), 32'd0);
        chk("rst_tgt_we", 32'(o_tgt_we), 32'd0);
        chk("rst_tgt_wdata", 32'(o_tgt_wdata), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
        chk("rst_rsp_region", 32'(o_rsp_region), 32'd0);
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        outstanding = 0;
        i_rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || outstanding) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", 32'(n < 300), 32'd1);
    endtask

    initial begin : responder
        plan_t cur;
        bit active;
        int k;
        active = 0;
        k = 0;
        rdata_r = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                active = 0;
                ack_r = 1'b0;
                plan_q.delete();
            end else if (o_tgt_valid) begin
                if (!active) begin
                    chk("tgt_expected", 32'(plan_q.size() != 0), 32'd1);
                    if (plan_q.size() != 0) begin
                        cur = plan_q.pop_front();
                        active = 1;
                        k = 0;
                    end
                end
                if (active) begin
                    chk("tgt_sel", 32'(o_tgt_sel), 32'(cur.sel));
                    chk("tgt_addr", 32'(o_tgt_addr), 32'(cur.addr));
                    chk("tgt_we", 32'(o_tgt_we), 32'(cur.we));
                    chk("tgt_wdata", 32'(o_tgt_wdata), 32'(cur.wdata));
                    if (!cur.stall && k == cur.delay) begin
                        ack_r = 1'b1;
                        rdata_r = cur.rdata;
                        active = 0;
                    end else begin
                        ack_r = 1'b0;
                        rdata_r = 16'($urandom);
                        k++;
                    end
                end else begin
                    ack_r = 1'b0;
                end
            end else begin
                if (active) begin
                    chk("tgt_dropped", 32'(cur.stall), 32'd1);
                    active = 0;
                end
                ack_r = ($urandom_range(0, 3) == 0);
                rdata_r = 16'($urandom);
            end
        end
    end

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                rsp_q.delete();
            end else begin
                chk("req_ready", 32'(o_req_ready), 32'(!outstanding));
                if (!o_tgt_valid) chk("tgt_sel_idle", 32'(o_tgt_sel), 32'd0);
                if (o_rsp_valid) begin
                    chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
                        chk("rsp_rdata", 32'(o_rsp_rdata), 32'(e.rdata));
                        chk("rsp_region", 32'(o_rsp_region), 32'(e.region));
                        chk("rsp_latency", 32'(cyc + 1 - e.acc_n), 32'(e.lat));
                    end
                    outstanding = 0;
                end
            end
        end
    end

    initial begin : stim
        int nib;
        int r;
        logic [15:0] a;
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr = '0;
        i_req_we = 1'b0;
        i_req_wdata = '0;
        @(negedge clk);
        do_reset();

        do_req(16'h0123, 1'b0, 16'h1111, 0, 16'hBEEF, 0);
        do_req(16'h1FFF, 1'b1, 16'h5A5A, 2, 16'h1234, 0);
        do_req(16'h2500, 1'b0, 16'h0000, 1, 16'hCAFE, 0);
        do_req(16'hF800, 1'b0, 16'h0000, 0, 16'hF00D, 0);
        do_req(16'h5000, 1'b0, 16'h0000, 0, 16'h0000, 0);
        wait_idle();

`ifdef ROUTER_TIMEOUT_EN
        do_req(16'h3000, 1'b0, 16'h0000, 0, 16'h0000, 1);
        wait_idle();
        chk("ready_after_timeout", 32'(o_req_ready), 32'd1);
`else
        do_req(16'h3000, 1'b0, 16'h0000, 0, 16'h0000, 1);
        repeat (100) @(negedge clk);
        chk("stall_holds_bus", 32'(o_tgt_valid), 32'd1);
        do_reset();
`endif

        do_req(16'h1000, 1'b0, 16'h0000, 0, 16'h0000, 1);
        @(negedge clk);
        do_reset();
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        force_ack = 1'b0;
        chk("no_rsp_after_reset", 32'(rsp_q.size()), 32'd0);
        do_req(16'h1000, 1'b0, 16'h0000, 1, 16'h7777, 0);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 7);
            if (r <= 3) nib = r;
            else if (r == 4) nib = 15;
            else nib = $urandom_range(4, 14);
            a = 16'($urandom);
            a[15:12] = 4'(nib);
            do_req(a, 1'($urandom), 16'($urandom), $urandom_range(0, 3),
                   16'($urandom), 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("plan_drained", 32'(plan_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
